// File: rtl/cache_config.sv
// Shared configuration for the L1 cache level: geometry defaults, address
// slice positions and the enumerations used by the controller and line array.
package cache_config;

  localparam int CFG_ADDRESS_WIDTH = 32;
  localparam int CFG_DATA_WIDTH    = 32;
  localparam int CFG_BLOCK_SIZE    = 16;
  localparam int CFG_NUM_BLOCKS    = 4;
  localparam int CFG_TAG_WIDTH     = 24;

  // Address layout: {pid[31:30], tag[29:6], index[5:4], word[3:2], byte[1:0]}
  localparam int PID_MSB   = 31;
  localparam int TAG_LSB   = 6;
  localparam int INDEX_LSB = 4;
  localparam int WORD_LSB  = 2;

  // S is decoded but never produced; it is held for a future snoop port.
  typedef enum logic [1:0] {MESI_I, MESI_S, MESI_E, MESI_M} mesi_state_t;

  typedef enum logic [1:0] {IDLE, COMPARE, WRITE_BACK, ALLOCATE} l1_ctrl_state_t;

endpackage

// File: rtl/l1_line_array.sv
// Direct-mapped line storage: pid, tag, data block and MESI state per line.
// One write port (word merge or full refill), combinational read by index.
module l1_line_array
  import cache_config::*;
#(
  parameter int NUM_BLOCKS  = CFG_NUM_BLOCKS,
  parameter int PID_W       = 2,
  parameter int TAG_WIDTH   = CFG_TAG_WIDTH,
  parameter int DATA_WIDTH  = CFG_DATA_WIDTH,
  parameter int LINE_W      = CFG_BLOCK_SIZE * 8,
  parameter int INDEX_WIDTH = $clog2(NUM_BLOCKS),
  parameter int WORD_SEL_W  = $clog2(LINE_W / DATA_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INDEX_WIDTH-1:0] index,
  output logic [PID_W-1:0]       rd_pid,
  output logic [TAG_WIDTH-1:0]   rd_tag,
  output logic [LINE_W-1:0]      rd_data,
  output mesi_state_t            rd_state,
  input  logic                   word_we,
  input  logic [WORD_SEL_W-1:0]  word_sel,
  input  logic [DATA_WIDTH-1:0]  word_data,
  input  logic                   fill_we,
  input  logic [PID_W-1:0]       fill_pid,
  input  logic [TAG_WIDTH-1:0]   fill_tag,
  input  logic [LINE_W-1:0]      fill_data
);

  logic [PID_W-1:0]     pid_mem   [NUM_BLOCKS];
  logic [TAG_WIDTH-1:0] tag_mem   [NUM_BLOCKS];
  logic [LINE_W-1:0]    data_mem  [NUM_BLOCKS];
  mesi_state_t          state_mem [NUM_BLOCKS];

  assign rd_pid   = pid_mem[index];
  assign rd_tag   = tag_mem[index];
  assign rd_data  = data_mem[index];
  assign rd_state = state_mem[index];

  // Coherence state: reset invalidates every line; refill -> E, store -> M.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_BLOCKS; i++) state_mem[i] <= MESI_I;
    end else if (fill_we) begin
      state_mem[index] <= MESI_E;
    end else if (word_we) begin
      state_mem[index] <= MESI_M;
    end
  end

  // Payload: not cleared by reset, but no write may land while reset is held.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (fill_we) begin
        pid_mem[index]  <= fill_pid;
        tag_mem[index]  <= fill_tag;
        data_mem[index] <= fill_data;
      end else if (word_we) begin
        data_mem[index][word_sel*DATA_WIDTH +: DATA_WIDTH] <= word_data;
      end
    end
  end

endmodule

// File: rtl/l1_cache_controller.sv
// L1 cache sequencing controller: tag compare, dirty-victim write-back and
// block refill for a direct-mapped write-back cache. Storage lives in
// l1_line_array; this module holds the FSM only.
module l1_cache_controller
  import cache_config::*;
#(
  parameter int ADDRESS_WIDTH = CFG_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = CFG_DATA_WIDTH,
  parameter int BLOCK_SIZE    = CFG_BLOCK_SIZE,
  parameter int NUM_BLOCKS    = CFG_NUM_BLOCKS,
  parameter int TAG_WIDTH     = CFG_TAG_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_req_valid,
  input  logic                      cpu_req_rw,
  input  logic [ADDRESS_WIDTH-1:0]  cpu_req_addr,
  input  logic [DATA_WIDTH-1:0]     cpu_req_wdata,
  output logic                      cpu_req_ready,
  output logic                      cpu_resp_valid,
  output logic [DATA_WIDTH-1:0]     cpu_resp_rdata,
  output logic                      mem_req_valid,
  output logic                      mem_req_rw,
  output logic [ADDRESS_WIDTH-1:0]  mem_req_addr,
  output logic [BLOCK_SIZE*8-1:0]   mem_req_wdata,
  input  logic                      mem_req_ready,
  input  logic                      mem_resp_valid,
  input  logic [BLOCK_SIZE*8-1:0]   mem_resp_rdata,
  output logic                      hit
);

  localparam int LINE_W      = BLOCK_SIZE * 8;
  localparam int INDEX_WIDTH = $clog2(NUM_BLOCKS);
  localparam int OFFSET_W    = $clog2(BLOCK_SIZE);
  localparam int WORD_SEL_W  = $clog2(LINE_W / DATA_WIDTH);
  localparam int PID_W       = PID_MSB - TAG_LSB - TAG_WIDTH + 1;

  l1_ctrl_state_t           state_q, state_d;
  logic                     replay_q, replay_d;
  logic                     req_rw_q, req_rw_d;
  logic [ADDRESS_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [DATA_WIDTH-1:0]    req_wdata_q, req_wdata_d;
  logic                     mem_req_valid_q, mem_req_valid_d;
  logic                     mem_req_rw_q, mem_req_rw_d;
  logic [ADDRESS_WIDTH-1:0] mem_req_addr_q, mem_req_addr_d;
  logic [LINE_W-1:0]        mem_req_wdata_q, mem_req_wdata_d;

  logic [PID_W-1:0]       req_pid, line_pid;
  logic [TAG_WIDTH-1:0]   req_tag, line_tag;
  logic [INDEX_WIDTH-1:0] req_index;
  logic [WORD_SEL_W-1:0]  req_word;
  logic [LINE_W-1:0]      line_data;
  mesi_state_t            line_state;
  logic                   line_hit, word_we, fill_we;
  logic                   unused_byte_bits;

  assign req_pid   = req_addr_q[PID_MSB -: PID_W];
  assign req_tag   = req_addr_q[TAG_LSB +: TAG_WIDTH];
  assign req_index = req_addr_q[INDEX_LSB +: INDEX_WIDTH];
  assign req_word  = req_addr_q[WORD_LSB +: WORD_SEL_W];
  assign unused_byte_bits = ^req_addr_q[WORD_LSB-1:0];

  l1_line_array #(
    .NUM_BLOCKS (NUM_BLOCKS),
    .PID_W      (PID_W),
    .TAG_WIDTH  (TAG_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .LINE_W     (LINE_W)
  ) u_lines (
    .clk       (clk),
    .rst       (rst),
    .index     (req_index),
    .rd_pid    (line_pid),
    .rd_tag    (line_tag),
    .rd_data   (line_data),
    .rd_state  (line_state),
    .word_we   (word_we),
    .word_sel  (req_word),
    .word_data (req_wdata_q),
    .fill_we   (fill_we),
    .fill_pid  (req_pid),
    .fill_tag  (req_tag),
    .fill_data (mem_resp_rdata)
  );

  assign line_hit = (line_state != MESI_I) && (line_pid == req_pid) && (line_tag == req_tag);

  // Completion is decoded from COMPARE so the response lands the cycle after accept.
  assign cpu_req_ready  = (state_q == IDLE);
  assign cpu_resp_valid = (state_q == COMPARE) && line_hit;
  assign hit            = cpu_resp_valid && !replay_q;
  assign cpu_resp_rdata = line_data[req_word*DATA_WIDTH +: DATA_WIDTH];

  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_rw    = mem_req_rw_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign mem_req_wdata = mem_req_wdata_q;

  // Next-state and next-output decode for the sequencing FSM.
  always_comb begin
    state_d         = state_q;
    replay_d        = replay_q;
    req_rw_d        = req_rw_q;
    req_addr_d      = req_addr_q;
    req_wdata_d     = req_wdata_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_req_rw_d    = mem_req_rw_q;
    mem_req_addr_d  = mem_req_addr_q;
    mem_req_wdata_d = mem_req_wdata_q;
    word_we         = 1'b0;
    fill_we         = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req_valid) begin
          req_rw_d    = cpu_req_rw;
          req_addr_d  = cpu_req_addr;
          req_wdata_d = cpu_req_wdata;
          replay_d    = 1'b0;
          state_d     = COMPARE;
        end
      end
      COMPARE: begin
        if (line_hit) begin
          word_we = req_rw_q;
          state_d = IDLE;
        end else if (line_state == MESI_M) begin
          mem_req_valid_d = 1'b1;
          mem_req_rw_d    = 1'b1;
          mem_req_addr_d  = {line_pid, line_tag, req_index, {OFFSET_W{1'b0}}};
          mem_req_wdata_d = line_data;
          state_d         = WRITE_BACK;
        end else begin
          // Clean or invalid victims are simply overwritten by the refill.
          mem_req_valid_d = 1'b1;
          mem_req_rw_d    = 1'b0;
          mem_req_addr_d  = {req_pid, req_tag, req_index, {OFFSET_W{1'b0}}};
          state_d         = ALLOCATE;
        end
      end
      WRITE_BACK: begin
        if (mem_req_ready) begin
          mem_req_rw_d   = 1'b0;
          mem_req_addr_d = {req_pid, req_tag, req_index, {OFFSET_W{1'b0}}};
          state_d        = ALLOCATE;
        end
      end
      ALLOCATE: begin
        if (mem_req_ready) mem_req_valid_d = 1'b0;
        // Refill is only trusted once the read has been accepted (now or earlier).
        if (mem_resp_valid && (!mem_req_valid_q || mem_req_ready)) begin
          fill_we         = 1'b1;
          mem_req_valid_d = 1'b0;
          replay_d        = 1'b1;
          state_d         = COMPARE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and registered memory-request outputs; reset touches control only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      replay_q        <= 1'b0;
      mem_req_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      replay_q        <= replay_d;
      mem_req_valid_q <= mem_req_valid_d;
    end
    req_rw_q        <= req_rw_d;
    req_addr_q      <= req_addr_d;
    req_wdata_q     <= req_wdata_d;
    mem_req_rw_q    <= mem_req_rw_d;
    mem_req_addr_q  <= mem_req_addr_d;
    mem_req_wdata_q <= mem_req_wdata_d;
  end

endmodule

// File: doc/l1_cache_controller.md
# l1_cache_controller

Sequencing controller for the L1 cache level: a direct-mapped, write-back cache of 4 blocks × 16 bytes. It accepts single-word CPU loads and stores, performs the tag compare, and on a miss evicts a dirty victim and refills the block over a 128-bit main-memory port. It sits between the processor load/store port and main memory. Per-line coherence state uses MESI encoding.

## Interface
Parameters (defaults from `cache_config`):
- `ADDRESS_WIDTH`, 32, CPU/memory address width
- `DATA_WIDTH`, 32, CPU word width
- `BLOCK_SIZE`, 16, block bytes; memory data width = `BLOCK_SIZE*8` = 128
- `NUM_BLOCKS`, 4, lines (direct-mapped, `INDEX_WIDTH` = 2)
- `TAG_WIDTH`, 24, tag bits; address = {pid[31:30], tag[29:6], index[5:4], word[3:2], byte[1:0]}

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1, sole clock, rising edge
- `rst` in 1, synchronous active-high reset
- `cpu_req_valid` in 1, CPU request present
- `cpu_req_rw` in 1, 1 = store, 0 = load
- `cpu_req_addr` in 32, byte address; [1:0] ignored
- `cpu_req_wdata` in 32, store word
- `cpu_req_ready` out 1, controller can accept a request
- `cpu_resp_valid` out 1, one-cycle completion pulse
- `cpu_resp_rdata` out 32, load data, valid with `cpu_resp_valid`
- `mem_req_valid` out 1, memory request
- `mem_req_rw` out 1, 1 = block write, 0 = block read
- `mem_req_addr` out 32, block-aligned address, [3:0] = 0
- `mem_req_wdata` out 128, victim block, word 0 in [31:0]
- `mem_req_ready` in 1, memory accepts the request
- `mem_resp_valid` in 1, refill data present
- `mem_resp_rdata` in 128, refill block
- `hit` out 1, pulse with `cpu_resp_valid` if first compare hit

## Operation
- Per-line storage: pid (2 bits), tag (24 bits), data (128 bits), MESI (2 bits). A line hits when state ≠ I and {pid, tag} match.
- FSM states: IDLE, COMPARE, WRITE_BACK, ALLOCATE.
- IDLE: `cpu_req_ready`=1. On `cpu_req_valid`, latch rw/addr/wdata → COMPARE.
- COMPARE, hit, load: return word[3:2]; pulse `cpu_resp_valid`; MESI unchanged → IDLE.
- COMPARE, hit, store: merge word; state → M (from E, S, or M); pulse `cpu_resp_valid` → IDLE.
- COMPARE, miss, victim M → WRITE_BACK. Victim I/E/S → ALLOCATE. Clean victims are dropped silently.
- WRITE_BACK: `mem_req_valid`=1, `rw`=1, addr = {victim pid, victim tag, index, 4'b0}. On `mem_req_ready` → ALLOCATE.
- ALLOCATE: issue read with addr = {req pid, req tag, index, 4'b0}. `mem_req_valid` drops after the handshake cycle. Wait for `mem_resp_valid`, then write the line, set state E → COMPARE. The replayed compare now hits; `hit`=0 for this request.
- S is decoded but never produced; it is reserved for a later snoop port.

## Timing
- Reset: FSM → IDLE; all lines → I; `cpu_resp_valid`, `mem_req_valid`, and `hit` = 0; `cpu_req_ready`=1 the cycle after reset deasserts. Data/tag arrays are not cleared.
- Hit latency: request accepted at edge N; response pulse during cycle N+1; next request can be accepted at N+2.
- Clean miss: 1 compare + mem handshake + response wait + 1 replay compare.
- `mem_req_*` remain stable while `mem_req_valid`=1 && !`mem_req_ready`.
- `mem_resp_valid` outside ALLOCATE-after-handshake is ignored.
- `cpu_req_valid` while `cpu_req_ready`=0 is ignored; the CPU holds it.
- `rst` mid-miss: outstanding transaction abandoned; `mem_req_valid`=0 next cycle; no line updated.
- `mem_req_ready` and `mem_resp_valid` may arrive in the same cycle as the read request. Refill is then captured that cycle, and ALLOCATE → COMPARE.

## Structure
- Add to `cache_config`: `typedef enum logic [1:0] {MESI_I, MESI_S, MESI_E, MESI_M} mesi_state_t`; `typedef enum logic [1:0] {IDLE, COMPARE, WRITE_BACK, ALLOCATE} l1_ctrl_state_t`; slice constants PID_MSB=31, TAG_LSB=6, INDEX_LSB=4, WORD_LSB=2.
- Sub-module `l1_line_array`: storage for tag/pid/data/MESI, one write port with word-merge enable and full-block refill, combinational read by index. The controller holds the FSM only.

## Test plan
- Cold load 0x0000_0040 → miss, mem read of 0x0000_0040; refill word1 = 0xDEAD_BEEF; load 0x...44 later → `hit`=1, rdata 0xDEAD_BEEF one cycle after accept.
- Store 0x1234_5678 to 0x40 after refill → line M. Load 0x0000_0140 (same index 0) → mem write of addr 0x40 with merged block, then read of 0x140.
- Clean eviction: E line at 0x80 replaced by 0x180 → no mem write, single read request only.
- Hold `mem_req_ready`=0 for 5 cycles in WRITE_BACK → addr/wdata stable all 5 cycles; a single accepted request.
- Assert `rst` for one cycle while waiting in ALLOCATE → `mem_req_valid`=0 and `cpu_req_ready`=1 next cycle; reload of the same address misses.
- pid differs (0x4000_0040 vs 0x0000_0040) → treated as miss.
